// File: rtl/cgra_exec_pkg.sv
// Shared types and defaults for the PE array execution controller.
// Optional stats output is enabled by defining PE_ARRAY_EXEC_STATS_EN.
package cgra_exec_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } exec_state_t;

  localparam int DEF_SYS_DWIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_STORE_LAT  = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  // Holds a count of up to STORE_LAT+1 outstanding busy steps.
  function automatic int inflight_width(input int store_lat);
    return $clog2(store_lat + 1) + 1;
  endfunction

endpackage

// File: rtl/exec_store_fifo.sv
// Store-pair FIFO: power-of-two depth, occupancy count, push and pop
// permitted in the same cycle at any occupancy (including full).
module exec_store_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The upstream credit scheme must never push into a full FIFO without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop_ok && count == FULL));

endmodule

// File: rtl/pe_array_exec_ctrl.sv
// Execution controller feeding load pairs to the PE array and collecting store pairs.
// Define PE_ARRAY_EXEC_STATS_EN to add the Stall_Count output.
module pe_array_exec_ctrl
  import cgra_exec_pkg::*;
#(
  parameter int SYS_DWIDTH = DEF_SYS_DWIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int STORE_LAT  = DEF_STORE_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [CNT_WIDTH-1:0]  Run_Cycles,
  output logic                  Done,
  input  logic                  Load_Valid,
  output logic                  Load_Ready,
  input  logic [SYS_DWIDTH-1:0] Load_Data0,
  input  logic [SYS_DWIDTH-1:0] Load_Data1,
  output logic [SYS_DWIDTH-1:0] Data0_Load,
  output logic [SYS_DWIDTH-1:0] Data1_Load,
  input  logic [SYS_DWIDTH-1:0] Data0_Store,
  input  logic [SYS_DWIDTH-1:0] Data1_Store,
  output logic                  PE_Array_Busy,
  output logic                  Store_Valid,
  input  logic                  Store_Ready,
  output logic [SYS_DWIDTH-1:0] Store_Data0,
  output logic [SYS_DWIDTH-1:0] Store_Data1
`ifdef PE_ARRAY_EXEC_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  Stall_Count
`endif
);

  localparam int IW  = inflight_width(STORE_LAT);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CRW = ((FCW > IW) ? FCW : IW) + 1;

  exec_state_t            state;
  logic [CNT_WIDTH-1:0]   run_len;
  logic [CNT_WIDTH-1:0]   step_cnt;
  logic [STORE_LAT:0]     vld_pipe;
  logic [IW-1:0]          inflight;
  logic [FCW-1:0]         fifo_count;
  logic [CRW-1:0]         credit_used;
  logic [2*SYS_DWIDTH-1:0] head;
  logic                   fire, push, pop, drain_done;

  // vld_pipe[0] is the live busy step; vld_pipe[k] is that step delayed by k.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= STORE_LAT; i++) inflight = inflight + IW'(vld_pipe[i]);
  end

  // Every step not yet popped holds a FIFO slot, so the FIFO can never overflow.
  assign credit_used   = CRW'(fifo_count) + CRW'(inflight);
  assign fire          = (state == S_RUN) && Load_Valid && (credit_used < CRW'(FIFO_DEPTH));
  assign Load_Ready    = fire;
  assign PE_Array_Busy = vld_pipe[0];
  assign push          = vld_pipe[STORE_LAT];
  assign pop           = Store_Valid && Store_Ready;
  assign drain_done    = (vld_pipe == '0) &&
                         ((fifo_count == '0) || ((fifo_count == FCW'(1)) && pop));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      run_len    <= '0;
      step_cnt   <= '0;
      vld_pipe   <= '0;
      Data0_Load <= '0;
      Data1_Load <= '0;
      Done       <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STORE_LAT-1:0], fire};
      Done     <= 1'b0;
      if (fire) begin
        Data0_Load <= Load_Data0;
        Data1_Load <= Load_Data1;
        step_cnt   <= step_cnt + CNT_WIDTH'(1);
      end
      case (state)
        S_IDLE: begin
          if (Start) begin
            run_len  <= Run_Cycles;
            step_cnt <= '0;
            if (Run_Cycles == '0) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (fire && (step_cnt == run_len - CNT_WIDTH'(1))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_done) begin
            state <= S_DONE;
            Done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PE_ARRAY_EXEC_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Stall_Count <= '0;
    end else if ((state == S_IDLE) && Start) begin
      Stall_Count <= '0;
    end else if ((state == S_RUN) && !fire && (Stall_Count != '1)) begin
      Stall_Count <= Stall_Count + CNT_WIDTH'(1);
    end
  end
`endif

  exec_store_fifo #(
    .WIDTH (2*SYS_DWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_store_fifo (
    .clk   (Clk),
    .reset (Reset),
    .push  (push),
    .wdata ({Data0_Store, Data1_Store}),
    .pop   (pop),
    .rdata (head),
    .valid (Store_Valid),
    .count (fifo_count)
  );

  assign Store_Data0 = head[2*SYS_DWIDTH-1:SYS_DWIDTH];
  assign Store_Data1 = head[SYS_DWIDTH-1:0];

endmodule

// File: tb/tb_pe_array_exec_ctrl.sv
// Randomized bench for pe_array_exec_ctrl against a transaction-level reference model.
// Stall_Count checks are compiled in when PE_ARRAY_EXEC_STATS_EN is defined.
module tb_pe_array_exec_ctrl;

  localparam int W     = 32;
  localparam int CW    = 16;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic          Clk = 1'b0;
  logic          Reset, Start, Done, Load_Valid, Load_Ready, PE_Array_Busy;
  logic          Store_Valid, Store_Ready;
  logic [CW-1:0] Run_Cycles;
  logic [W-1:0]  Load_Data0, Load_Data1, Data0_Load, Data1_Load;
  logic [W-1:0]  Data0_Store, Data1_Store, Store_Data0, Store_Data1;
`ifdef PE_ARRAY_EXEC_STATS_EN
  logic [CW-1:0] Stall_Count;
`endif

  always #5 Clk = ~Clk;

  pe_array_exec_ctrl #(.SYS_DWIDTH(W), .CNT_WIDTH(CW), .STORE_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Run_Cycles(Run_Cycles), .Done(Done),
    .Load_Valid(Load_Valid), .Load_Ready(Load_Ready),
    .Load_Data0(Load_Data0), .Load_Data1(Load_Data1),
    .Data0_Load(Data0_Load), .Data1_Load(Data1_Load),
    .Data0_Store(Data0_Store), .Data1_Store(Data1_Store),
    .PE_Array_Busy(PE_Array_Busy), .Store_Valid(Store_Valid), .Store_Ready(Store_Ready),
    .Store_Data0(Store_Data0), .Store_Data1(Store_Data1)
`ifdef PE_ARRAY_EXEC_STATS_EN
    , .Stall_Count(Stall_Count)
`endif
  );

  // Array model: store ports show the loaded pair + 0x10, STORE_LAT cycles later.
  logic [LAT-1:0][W-1:0] arr0, arr1;
  always @(posedge Clk) begin
    arr0 <= {arr0, Data0_Load + 32'h10};
    arr1 <= {arr1, Data1_Load + 32'h10};
  end
  assign Data0_Store = arr0[LAT-1];
  assign Data1_Store = arr1[LAT-1];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model state: run phase, accepted/popped totals, expected payloads.
  bit          chk_en = 0;
  bit          run_ph = 0, drain_ph = 0, done_exp = 0, busy_exp = 0;
  int          n_len = 0, acc = 0, pops = 0, stall_exp = 0;
  logic [W-1:0] ld0_exp = '0, ld1_exp = '0;
  logic [63:0] exp_q[$];
  logic [63:0] last_pop = '0;
  int          ready_cnt = 0, busy_cnt = 0, done_cnt = 0, pop_cnt = 0;

  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      bit exp_ready, idle, nxt_done;
      exp_ready = run_ph && Load_Valid && ((acc - pops) < DEPTH);
      chk("load_ready", 64'(Load_Ready), 64'(exp_ready));
      chk("busy", 64'(PE_Array_Busy), 64'(busy_exp));
      chk("data_load", {Data0_Load, Data1_Load}, {ld0_exp, ld1_exp});
      chk("done", 64'(Done), 64'(done_exp));
      if (pops == acc) chk("store_valid_empty", 64'(Store_Valid), 64'(0));
`ifdef PE_ARRAY_EXEC_STATS_EN
      chk("stall_count", 64'(Stall_Count), 64'(stall_exp));
`endif
      if (Load_Ready) ready_cnt++;
      if (PE_Array_Busy) busy_cnt++;
      if (Done) done_cnt++;
      if (Store_Valid && Store_Ready && !Reset) begin
        pop_cnt++;
        last_pop = {Store_Data0, Store_Data1};
        if (exp_q.size() == 0) chk("pop_unexpected", 64'(1), 64'(0));
        else chk("store_pair", last_pop, exp_q.pop_front());
        pops++;
      end
      if (Reset) begin
        run_ph = 0; drain_ph = 0; done_exp = 0; busy_exp = 0;
        acc = 0; pops = 0; stall_exp = 0; ld0_exp = '0; ld1_exp = '0;
        exp_q.delete();
      end else begin
        idle = !run_ph && !drain_ph && !done_exp;
        nxt_done = 0;
        if (exp_ready) begin
          acc++;
          ld0_exp = Load_Data0;
          ld1_exp = Load_Data1;
          exp_q.push_back({Load_Data0 + 32'h10, Load_Data1 + 32'h10});
        end
        busy_exp = exp_ready;
        if (run_ph && !exp_ready && stall_exp < 65535) stall_exp++;
        if (run_ph && acc == n_len) begin run_ph = 0; drain_ph = 1; end
        if (Start && idle) begin
          n_len = int'(Run_Cycles); acc = 0; pops = 0; stall_exp = 0;
          exp_q.delete();
          if (n_len == 0) drain_ph = 1; else run_ph = 1;
        end
        if (drain_ph && pops == acc) begin drain_ph = 0; nxt_done = 1; end
        done_exp = nxt_done;
      end
    end
  end

  logic [W-1:0] tab0[64], tab1[64];

  // vmode: 0 always valid, 1 random, 2 two-cycle gap; rmode: 0 ready, 1 random, 2 held off 30 cycles.
  task automatic run(input int n, input int vmode, input int rmode, input bit seq,
                     input int ign_cyc, input int rst_at);
    int cyc, k, r0, b0, p0, d0;
    r0 = ready_cnt; b0 = busy_cnt; p0 = pop_cnt; d0 = done_cnt;
    Start = 1; Run_Cycles = CW'(n); Load_Valid = 0; Store_Ready = (rmode != 2);
    @(posedge Clk); #1;
    Start = 0;
    cyc = 0;
    while (done_cnt == d0 && cyc < 400) begin
      k = ready_cnt - r0;
      case (vmode)
        0:       Load_Valid = 1;
        1:       Load_Valid = 1'($urandom_range(0, 1));
        default: Load_Valid = !(cyc == 3 || cyc == 4);
      endcase
      case (rmode)
        0:       Store_Ready = 1;
        1:       Store_Ready = ($urandom_range(0, 3) != 0);
        default: Store_Ready = (cyc >= 30);
      endcase
      Load_Data0 = seq ? W'(2*k + 1) : tab0[k % 64];
      Load_Data1 = seq ? W'(2*k + 2) : tab1[k % 64];
      Start = (cyc == ign_cyc);
      Run_Cycles = (cyc == ign_cyc) ? CW'(n + 4) : CW'(n);
      if (rmode == 2 && cyc == 20) chk("bp_fires_capped", 64'(ready_cnt - r0), 64'(DEPTH));
      if (rst_at > 0 && (ready_cnt - r0) >= rst_at) begin
        Reset = 1; Load_Valid = 0; Start = 0;
        @(posedge Clk); #1;
        Reset = 0;
        @(negedge Clk);
        chk("rst_outputs", {60'(0), Done, Load_Ready, PE_Array_Busy, Store_Valid}, 64'(0));
        chk("rst_data_load", {Data0_Load, Data1_Load}, 64'(0));
        chk("rst_store_data", {Store_Data0, Store_Data1}, 64'(0));
        repeat (6) @(posedge Clk);
        #1;
        chk("rst_no_done", 64'(done_cnt - d0), 64'(0));
        return;
      end
      @(posedge Clk); #1;
      cyc++;
    end
    Start = 0; Load_Valid = 0; Store_Ready = 1;
    chk("run_timeout", 64'(done_cnt != d0), 64'(1));
    chk("fires", 64'(ready_cnt - r0), 64'(n));
    chk("busy_cycles", 64'(busy_cnt - b0), 64'(n));
    chk("pops", 64'(pop_cnt - p0), 64'(n));
    chk("done_pulses", 64'(done_cnt - d0), 64'(1));
  endtask

  initial begin
    Reset = 1; Start = 0; Run_Cycles = '0; Load_Valid = 0;
    Load_Data0 = '0; Load_Data1 = '0; Store_Ready = 0;
    for (int i = 0; i < 64; i++) begin
      tab0[i] = $urandom;
      tab1[i] = $urandom;
    end
    repeat (2) @(posedge Clk);
    #1 chk_en = 1;
    @(negedge Clk);
    chk("reset_outputs", {60'(0), Done, Load_Ready, PE_Array_Busy, Store_Valid}, 64'(0));
    chk("reset_store_data", {Store_Data0, Store_Data1}, 64'(0));
    @(posedge Clk); #1;
    Reset = 0;
    @(posedge Clk); #1;

    run(3, 0, 0, 1, -1, 0);
    chk("basic_last_pair", last_pop, {32'h15, 32'h16});
    run(4, 2, 0, 0, -1, 0);
`ifdef PE_ARRAY_EXEC_STATS_EN
    chk("starve_stall_count", 64'(Stall_Count), 64'(2));
`endif
    run(8, 0, 2, 0, -1, 0);
    run(0, 0, 0, 0, -1, 0);
    run(5, 0, 0, 0, 1, 0);
    run(5, 0, 0, 0, -1, 2);
    run(1, 0, 0, 0, -1, 0);
    for (int t = 0; t < 8; t++) run($urandom_range(1, 12), 1, 1, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
